// File: rtl/calc_pkg.sv
// Shared display-bus definitions: digit codes, active-high segment patterns
// (index 0 = segment a ... index 6 = segment g) and capture FSM states.
package calc_pkg;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    localparam logic [0:6] SEG_0     = 7'b1111110;
    localparam logic [0:6] SEG_1     = 7'b0110000;
    localparam logic [0:6] SEG_2     = 7'b1101101;
    localparam logic [0:6] SEG_3     = 7'b1111001;
    localparam logic [0:6] SEG_4     = 7'b0110011;
    localparam logic [0:6] SEG_5     = 7'b1011011;
    localparam logic [0:6] SEG_6     = 7'b1011111;
    localparam logic [0:6] SEG_7     = 7'b1110000;
    localparam logic [0:6] SEG_8     = 7'b1111111;
    localparam logic [0:6] SEG_9     = 7'b1111011;
    localparam logic [0:6] SEG_MINUS = 7'b0000001;
    localparam logic [0:6] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    function automatic logic [2:0] count_ones(input logic [0:3] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Display bus (seg/dot/en) plus the published frame and error pulses.
interface seg_scan_capture_if;

    logic [0:6]  seg;
    logic        dot;
    logic [0:3]  en;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic        frame_valid;
    logic        err_invalid;
    logic        err_multi;

    modport master (
        output seg, dot, en,
        input  digits, dots, frame_valid, err_invalid, err_multi
    );

    modport slave (
        input  seg, dot, en,
        output digits, dots, frame_valid, err_invalid, err_multi
    );

endinterface

// File: rtl/seg7_decode.sv
// Active-high 7-segment pattern to digit code; inverse of the display encoder.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [0:6] pattern,
    output logic       valid,
    output logic [3:0] code
);

    always_comb begin
        valid = 1'b1;
        code  = DIG_BLANK;
        case (pattern)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_MINUS: code = DIG_MINUS;
            SEG_BLANK: code = DIG_BLANK;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples the multiplexed display bus, waits for each anode window to settle,
// decodes the digit and publishes a complete four-digit frame atomically.
module seg_scan_capture
    import calc_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_capture_if.slave  bus
);

    logic [0:6]  seg_snap_q, seg_snap_d, seg_prev_q;
    logic        dot_snap_q, dot_snap_d, dot_prev_q;
    logic [0:3]  en_snap_q, en_snap_d, en_prev_q;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_dot_q, shadow_dot_d;
    logic [3:0]  seen_q, seen_d, seen_upd;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dots_q, dots_d;
    logic        frame_valid_q, frame_valid_d;
    logic        err_invalid_q, err_invalid_d;
    logic        err_multi_q, err_multi_d;

    logic        changed;
    logic [2:0]  n_en;
    logic [1:0]  pos;
    logic        dec_valid;
    logic [3:0]  dec_code;

    seg7_decode u_decode (
        .pattern (seg_snap_q),
        .valid   (dec_valid),
        .code    (dec_code)
    );

    always_comb begin
        seg_snap_d = ACTIVE_LOW ? ~bus.seg : bus.seg;
        dot_snap_d = ACTIVE_LOW ? ~bus.dot : bus.dot;
        en_snap_d  = ACTIVE_LOW ? ~bus.en  : bus.en;
    end

    always_comb begin
        changed = {seg_snap_q, dot_snap_q, en_snap_q} != {seg_prev_q, dot_prev_q, en_prev_q};
        n_en    = count_ones(en_snap_q);
        pos     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (en_snap_q[i]) pos = 2'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        shadow_dot_d  = shadow_dot_q;
        seen_d        = seen_q;
        seen_upd      = seen_q;
        digits_d      = digits_q;
        dots_d        = dots_q;
        frame_valid_d = 1'b0;
        err_invalid_d = 1'b0;
        err_multi_d   = 1'b0;

        if (changed) begin
            cnt_d = '0;
            if (n_en == 3'd1) begin
                state_d = SETTLE;
            end else begin
                state_d     = IDLE;
                err_multi_d = (n_en > 3'd1);
            end
        end else if (state_q == SETTLE) begin
            if (cnt_q == 8'(STABLE_CYCLES - 1)) begin
                state_d = HELD;
                if (dec_valid) begin
                    shadow_d[{pos, 2'b00} +: 4] = dec_code;
                    shadow_dot_d[pos]           = dot_snap_q;
                    seen_upd[pos]               = 1'b1;
                    // Publish from the updated shadow so the final capture lands in this frame.
                    if (&seen_upd) begin
                        digits_d      = shadow_d;
                        dots_d        = shadow_dot_d;
                        frame_valid_d = 1'b1;
                        seen_d        = '0;
                    end else begin
                        seen_d = seen_upd;
                    end
                end else begin
                    err_invalid_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_snap_q    <= '0;
            dot_snap_q    <= 1'b0;
            en_snap_q     <= '0;
            seg_prev_q    <= '0;
            dot_prev_q    <= 1'b0;
            en_prev_q     <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            shadow_dot_q  <= '0;
            seen_q        <= '0;
            digits_q      <= '1;
            dots_q        <= '0;
            frame_valid_q <= 1'b0;
            err_invalid_q <= 1'b0;
            err_multi_q   <= 1'b0;
        end else begin
            seg_snap_q    <= seg_snap_d;
            dot_snap_q    <= dot_snap_d;
            en_snap_q     <= en_snap_d;
            seg_prev_q    <= seg_snap_q;
            dot_prev_q    <= dot_snap_q;
            en_prev_q     <= en_snap_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            shadow_dot_q  <= shadow_dot_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            dots_q        <= dots_d;
            frame_valid_q <= frame_valid_d;
            err_invalid_q <= err_invalid_d;
            err_multi_q   <= err_multi_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dots        = dots_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_invalid = err_invalid_q;
    assign bus.err_multi   = err_multi_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: expected frames are queued as each
// scan is driven and compared when frame_valid fires; error pulses are counted.
module tb_seg_scan_capture;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg_scan_capture_if bus();

    seg_scan_capture #(
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dots;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned frames   = 0;
    int unsigned multi_n  = 0;
    int unsigned inval_n  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Active-high patterns, a..g left to right; 10 = minus, 11 = blank.
    function automatic logic [0:6] seg_ah(input int d);
        case (d)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic drive_raw(input logic [0:3] en_al, input logic [0:6] seg_al,
                             input logic dot_al, input int n);
        bus.en  = en_al;
        bus.seg = seg_al;
        bus.dot = dot_al;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input int pos, input int d, input logic dot_lit, input int n);
        logic [0:3] e;
        e = '0;
        e[pos] = 1'b1;
        drive_raw(~e, ~seg_ah(d), ~dot_lit, n);
    endtask

    task automatic idle(input int n);
        drive_raw(4'b1111, 7'b1111111, 1'b1, n);
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] p);
        frame_t f;
        f.digits = d;
        f.dots   = p;
        exp_q.push_back(f);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid) begin
                frames++;
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 32'd1, 32'd0);
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    check("frame_digits", {16'h0, bus.digits}, {16'h0, f.digits});
                    check("frame_dots", {28'h0, bus.dots}, {28'h0, f.dots});
                end
            end
            if (bus.err_multi)   multi_n++;
            if (bus.err_invalid) inval_n++;
        end
    end

    initial begin
        int unsigned f0, m0, i0;

        rst_n = 1'b0;
        bus.en  = 4'b1111;
        bus.seg = 7'b1111111;
        bus.dot = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_digits", {16'h0, bus.digits}, 32'h0000_FFFF);
        check("rst_dots", {28'h0, bus.dots}, 32'h0);
        check("rst_frame_valid", {31'h0, bus.frame_valid}, 32'h0);
        check("rst_errs", {30'h0, bus.err_invalid, bus.err_multi}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // Basic scan 5,2,3,6
        f0 = frames; m0 = multi_n; i0 = inval_n;
        push_frame(16'h6325, 4'h0);
        scan(0, 5, 1'b0, 8);
        scan(1, 2, 1'b0, 8);
        scan(2, 3, 1'b0, 8);
        scan(3, 6, 1'b0, 8);
        idle(10);
        check("basic_frames", frames - f0, 32'd1);
        check("basic_errs", (multi_n - m0) + (inval_n - i0), 32'd0);
        check("basic_hold_digits", {16'h0, bus.digits}, 32'h0000_6325);

        // Short window on position 2 must not capture
        f0 = frames;
        push_frame(16'h0987, 4'h0);
        scan(0, 7, 1'b0, 8);
        scan(1, 8, 1'b0, 8);
        scan(2, 9, 1'b0, 3);
        scan(3, 0, 1'b0, 8);
        check("short_no_frame", frames - f0, 32'd0);
        check("short_digits_held", {16'h0, bus.digits}, 32'h0000_6325);
        scan(2, 9, 1'b0, 5);
        idle(10);
        check("short_frames", frames - f0, 32'd1);

        // Two anodes active
        f0 = frames; m0 = multi_n; i0 = inval_n;
        drive_raw(4'b0011, ~seg_ah(8), 1'b1, 6);
        idle(10);
        check("multi_count", multi_n - m0, 32'd1);
        check("multi_no_frame", frames - f0, 32'd0);
        check("multi_no_invalid", inval_n - i0, 32'd0);

        // Minus with lit dot, blanks elsewhere
        f0 = frames;
        push_frame(16'hFFAF, 4'b0010);
        scan(0, 11, 1'b0, 8);
        scan(1, 10, 1'b1, 8);
        scan(2, 11, 1'b0, 8);
        scan(3, 11, 1'b0, 8);
        idle(10);
        check("minus_frames", frames - f0, 32'd1);

        // Invalid pattern on position 3
        f0 = frames; i0 = inval_n;
        push_frame(16'h9841, 4'h0);
        scan(0, 1, 1'b0, 8);
        scan(1, 4, 1'b0, 8);
        scan(2, 8, 1'b0, 8);
        drive_raw(4'b1110, 7'b1010101, 1'b1, 8);
        check("invalid_count", inval_n - i0, 32'd1);
        check("invalid_no_frame", frames - f0, 32'd0);
        scan(3, 9, 1'b0, 8);
        idle(10);
        check("invalid_frames", frames - f0, 32'd1);
        check("invalid_count_final", inval_n - i0, 32'd1);

        // Reset mid-frame discards partial captures
        scan(0, 2, 1'b0, 8);
        scan(1, 0, 1'b0, 8);
        scan(2, 1, 1'b0, 8);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(4);
        @(negedge clk);
        check("mid_rst_digits", {16'h0, bus.digits}, 32'h0000_FFFF);
        check("mid_rst_dots", {28'h0, bus.dots}, 32'h0);
        #1;
        f0 = frames;
        push_frame(16'h8765, 4'h0);
        scan(0, 5, 1'b0, 8);
        scan(1, 6, 1'b0, 8);
        scan(2, 7, 1'b0, 8);
        check("rescan_partial", frames - f0, 32'd0);
        scan(3, 8, 1'b0, 8);
        idle(10);
        check("rescan_frames", frames - f0, 32'd1);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receiving end of the calculator's multiplexed 7-segment display bus (seg/dot/en).
- Samples the time-multiplexed segment, dot and anode-enable lines and decodes each segment pattern back to a digit code.
- Assembles the four digits into a coherent frame and publishes it atomically with a one-cycle strobe.
- Used as an on-chip display readback/self-check block and as a scoreboard front end in benches.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples (one anode active) required before capture; legal range 2..255.
- ACTIVE_LOW, 1: 1 = seg, dot and en are active-low (board polarity); 0 = active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  [0:6]  segment lines; seg[0]=a … seg[6]=g.
- dot  in  1  decimal-point line.
- en  in  [0:3]  anode enables; en[i] selects digit position i.
- digits  out  [15:0]  published frame; digit i occupies bits [4i+3:4i].
- dots  out  [3:0]  published dot per position.
- frame_valid  out  1  one-cycle pulse when digits/dots update.
- err_invalid  out  1  one-cycle pulse: stable pattern not in the decode table.
- err_multi  out  1  one-cycle pulse: more than one anode active.

Behaviour:
- Digit codes: 0x0–0x9 for decimal digits, 0xA = minus (g only), 0xF = blank (all off); every other pattern is invalid.
- Input stage: ACTIVE_LOW inversion applied, then seg, dot and en are registered once (snap). All later logic uses snap and prev_snap.
- Reset (async): snap, prev_snap and shadow are cleared; digits=16'hFFFF (all blank); dots=0; seen=0; cnt=0; state=IDLE; all pulse outputs 0.
- States:
  - IDLE: no position being settled.
  - SETTLE: counting stability.
  - HELD: digit captured, waiting for snap to change.
- Change evaluation: each cycle where snap != prev_snap:
  - Exactly one en bit set → SETTLE, cnt=0.
  - Zero en bits set → IDLE.
  - Two or more en bits set → IDLE, and err_multi pulses for one cycle, once per change.
- SETTLE with snap unchanged: cnt increments. When cnt == STABLE_CYCLES-1, capture and go to HELD.
  - Capture latency: STABLE_CYCLES+1 clocks after the inputs settle.
- HELD: no further capture until snap changes, so there is exactly one capture per anode window.
- Capture of position i:
  - Valid pattern: shadow[i] <= code, shadow_dot[i] <= dot, seen[i] <= 1.
  - Invalid pattern: err_invalid pulses; seen and shadow are unchanged.
  - Duplicate capture of a position already seen: shadow overwritten silently. Scan order is arbitrary.
- Publish: when seen including the current capture equals 4'b1111, in the same cycle:
  - digits/dots <= shadow (including the new value);
  - frame_valid=1 on the next clock edge;
  - seen <= 0.
- Outputs are held between publishes. A partial frame is never visible on digits.
- Simultaneous events: a capture and a change cannot coincide, because capture requires snap unchanged. Publish and seen-clear happen in the same cycle.
- Reset asserted mid-frame discards shadow and seen. The first frame after reset needs all four positions again.

Decomposition:
- Shared package (calc_pkg):
  - digit code constants DIG_MINUS=4'hA and DIG_BLANK=4'hF;
  - the active-high segment pattern constants for 0–9, minus and blank;
  - the state enum {IDLE, SETTLE, HELD}.
- One sub-module, seg7_decode: combinational 7-bit pattern → {valid, code[3:0]}. It is the inverse of the calculator's encoder and is reused by benches.

Test Plan:
- Scan 5,2,3,6 on en positions 0..3, active-low, each held 8 cycles. seg per position:
  - 0100100 (5), 0010010 (2), 0000110 (3), 0100000 (6).
  - Required: one frame_valid, digits=16'h6325, dots=0, no errors.
- Position 2 held only 3 cycles (STABLE_CYCLES=4), other positions 8 cycles → no capture of position 2, no frame_valid. Position 2 then held 5 cycles → frame_valid.
- en=4'b0011 (active-low, two anodes active) for 6 cycles → err_multi exactly once, no capture.
- Position 1 driven with active-low 1111110 (minus), dot=0 (lit), other positions blank → digits=16'hFFAF, dots=4'b0010.
- Position 3 driven with 1010101 (invalid) → err_invalid once; frame completes only after position 3 is redriven with a valid pattern.
- rst_n low after positions 0–2 are captured, then released → digits=16'hFFFF, and no frame_valid until all four positions are rescanned.
